// File: rtl/tty_rx_pkg.sv
// Shared definitions for the TTY serial receiver (and the matching transmitter).
package tty_rx_pkg;

    // Receiver FSM encoding.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } rx_state_e;

    // Tick-count values within one bit period (16x oversampling).
    localparam logic [3:0] TickMid  = 4'd7;
    localparam logic [3:0] TickLast = 4'd15;

    localparam logic [2:0] LastDataBit = 3'd7;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/tty_rx_if.sv
// Keyboard-side signal bundle between the RxD pin, the receiver and the CPU IOT logic.
interface tty_rx_if;
    logic       rx;
    logic       rdStrobe;
    logic [7:0] data;
    logic       ready;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    // CPU / line side: drives the pin and the read strobe.
    modport master (
        output rx,
        output rdStrobe,
        input  data,
        input  ready,
        input  frameErr,
        input  overrun,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  rx,
        input  rdStrobe,
        output data,
        output ready,
        output frameErr,
        output overrun,
        output busy
    );
endinterface

// File: rtl/tty_rx_baud_tick.sv
// Free-running prescaler emitting a one-cycle tick every DIV clocks, with sync clear.
module baud_tick
    import tty_rx_pkg::*;
#(
    parameter int unsigned DIV = 163
) (
    input  logic clk,
    input  logic nReset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/tty_rx.sv
// 8N1 async receiver with 16x oversampling and a single-character KL8E-style buffer.
module tty_rx
    import tty_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic    clk,
    input logic    nReset,
    tty_rx_if.slave bus
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

    logic       rx_meta_q, rx_s_q;
    rx_state_e  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       commit_q, commit_d;
    logic       stop_bit_q, stop_bit_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       presc_clr;
    logic       tick;

    baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk    (clk),
        .nReset (nReset),
        .clr    (presc_clr),
        .tick   (tick)
    );

    // Two-flop synchroniser; resets to the idle (mark) level.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM next-state: start validation, data shifting, stop sampling, break wait.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        commit_d   = 1'b0;
        stop_bit_d = stop_bit_q;
        presc_clr  = 1'b0;

        if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        case (state_q)
            StIdle: begin
                tick_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = StStart;
                    // Align tick phase to the detected falling edge.
                    presc_clr = 1'b1;
                end
            end
            StStart: begin
                if (tick && (tick_cnt_q == TickMid)) begin
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (tick && (tick_cnt_q == TickLast)) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == LastDataBit) begin
                        state_d    = StStop;
                        tick_cnt_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tick && (tick_cnt_q == TickLast)) begin
                    stop_bit_d = rx_s_q;
                    commit_d   = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = rx_s_q ? StIdle : StBreak;
                end
            end
            StBreak: begin
                // Held-low line must return to mark before a new start is accepted.
                tick_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                tick_cnt_d = '0;
            end
        endcase
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            commit_q   <= 1'b0;
            stop_bit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            commit_q   <= commit_d;
            stop_bit_q <= stop_bit_d;
        end
    end

    // Holding register and flags; a commit beats a simultaneous read strobe.
    always_comb begin
        data_d      = data_q;
        ready_d     = ready_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (commit_q) begin
            data_d      = shift_q;
            ready_d     = 1'b1;
            frame_err_d = ~stop_bit_q;
            // A strobe in the commit cycle consumes the old character.
            overrun_d   = bus.rdStrobe ? 1'b0 : (overrun_q | ready_q);
        end else if (bus.rdStrobe && ready_q) begin
            ready_d     = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // Output holding registers.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data     = data_q;
    assign bus.ready    = ready_q;
    assign bus.frameErr = frame_err_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_tty_rx.sv
// Directed bench for tty_rx at DIV=4 (64 clocks per bit).
module tb_tty_rx;

    logic clk = 1'b0;
    logic nReset;
    int   checks = 0;
    int   errors = 0;
    int   rise_clk;

    tty_rx_if bus_if();

    tty_rx #(
        .CLK_HZ     (640000),
        .BAUD       (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe();
        @(negedge clk);
        bus_if.rdStrobe = 1'b1;
        @(negedge clk);
        bus_if.rdStrobe = 1'b0;
    endtask

    // Drives one 640-clock frame; optional reset pulse at clock rst_at and optional
    // read strobe in the first cycle busy is seen low after being high (commit cycle).
    task automatic send_frame(input logic [7:0] ch, input logic stop, input int rst_at,
                              input logic rd_at_commit);
        logic [9:0] frame;
        logic       prev_busy;
        logic       prev_ready;
        frame      = {stop, ch, 1'b0};
        rise_clk   = -1;
        prev_busy  = bus_if.busy;
        prev_ready = bus_if.ready;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (!prev_ready && bus_if.ready && (rise_clk < 0)) rise_clk = i;
            bus_if.rdStrobe = rd_at_commit && prev_busy && !bus_if.busy;
            nReset = (i == rst_at) ? 1'b0 : 1'b1;
            if ((rst_at >= 0) && (i == rst_at + 1)) begin
                check("rst_mid_data", bus_if.data, 8'h00);
                check("rst_mid_ready", {7'd0, bus_if.ready}, 8'h00);
                check("rst_mid_ferr", {7'd0, bus_if.frameErr}, 8'h00);
                check("rst_mid_ovr", {7'd0, bus_if.overrun}, 8'h00);
                check("rst_mid_busy", {7'd0, bus_if.busy}, 8'h00);
            end
            prev_busy  = bus_if.busy;
            prev_ready = bus_if.ready;
            bus_if.rx  = frame[i/64];
        end
        bus_if.rdStrobe = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        nReset = 1'b0;
        idle(2);
        nReset = 1'b1;
    endtask

    initial begin
        bus_if.rx       = 1'b1;
        bus_if.rdStrobe = 1'b0;
        nReset          = 1'b0;
        idle(3);
        nReset = 1'b1;

        // Reset state
        check("rst_data", bus_if.data, 8'h00);
        check("rst_ready", {7'd0, bus_if.ready}, 8'h00);
        check("rst_ferr", {7'd0, bus_if.frameErr}, 8'h00);
        check("rst_ovr", {7'd0, bus_if.overrun}, 8'h00);
        check("rst_busy", {7'd0, bus_if.busy}, 8'h00);
        idle(5);

        // 1: clean 0x41; ready expected 612 clocks after the start edge (limit 615)
        send_frame(8'h41, 1'b1, -1, 1'b0);
        idle(4);
        check("t1_data", bus_if.data, 8'h41);
        check("t1_ready", {7'd0, bus_if.ready}, 8'h01);
        check("t1_ferr", {7'd0, bus_if.frameErr}, 8'h00);
        check("t1_ovr", {7'd0, bus_if.overrun}, 8'h00);
        check("t1_busy", {7'd0, bus_if.busy}, 8'h00);
        check("t1_latency_ok", {7'd0, (rise_clk >= 0) && (rise_clk <= 615)}, 8'h01);
        strobe();
        check("t1_rd_ready", {7'd0, bus_if.ready}, 8'h00);
        check("t1_rd_data", bus_if.data, 8'h41);

        // 2: 20-clock glitch is rejected
        apply_reset();
        idle(5);
        bus_if.rx = 1'b0;
        idle(10);
        check("t2_busy_in_start", {7'd0, bus_if.busy}, 8'h01);
        idle(10);
        bus_if.rx = 1'b1;
        idle(60);
        check("t2_busy", {7'd0, bus_if.busy}, 8'h00);
        check("t2_ready", {7'd0, bus_if.ready}, 8'h00);
        check("t2_data", bus_if.data, 8'h00);

        // 3: framing error then break, then 0x0F overruns
        send_frame(8'h55, 1'b0, -1, 1'b0);
        idle(200);
        check("t3_busy_break", {7'd0, bus_if.busy}, 8'h01);
        check("t3_data", bus_if.data, 8'h55);
        check("t3_ready", {7'd0, bus_if.ready}, 8'h01);
        check("t3_ferr", {7'd0, bus_if.frameErr}, 8'h01);
        bus_if.rx = 1'b1;
        idle(20);
        check("t3_busy_idle", {7'd0, bus_if.busy}, 8'h00);
        check("t3_data_hold", bus_if.data, 8'h55);
        send_frame(8'h0F, 1'b1, -1, 1'b0);
        idle(4);
        check("t3b_data", bus_if.data, 8'h0F);
        check("t3b_ovr", {7'd0, bus_if.overrun}, 8'h01);
        check("t3b_ferr", {7'd0, bus_if.frameErr}, 8'h00);

        // 4: two characters unread, then read clears flags
        strobe();
        check("t4_pre_ready", {7'd0, bus_if.ready}, 8'h00);
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        idle(4);
        check("t4_data", bus_if.data, 8'h3C);
        check("t4_ready", {7'd0, bus_if.ready}, 8'h01);
        check("t4_ovr", {7'd0, bus_if.overrun}, 8'h01);
        strobe();
        check("t4_rd_ready", {7'd0, bus_if.ready}, 8'h00);
        check("t4_rd_ovr", {7'd0, bus_if.overrun}, 8'h00);
        check("t4_rd_data", bus_if.data, 8'h3C);

        // 5: read strobe coincides with commit of 0x7E
        send_frame(8'h11, 1'b1, -1, 1'b0);
        idle(4);
        check("t5_first_data", bus_if.data, 8'h11);
        send_frame(8'h7E, 1'b1, -1, 1'b1);
        idle(4);
        check("t5_ready", {7'd0, bus_if.ready}, 8'h01);
        check("t5_data", bus_if.data, 8'h7E);
        check("t5_ovr", {7'd0, bus_if.overrun}, 8'h00);

        // 6: reset during data bit 4 of 0xFF, then clean 0x12
        send_frame(8'hFF, 1'b1, 340, 1'b0);
        idle(10);
        check("t6_no_char", {7'd0, bus_if.ready}, 8'h00);
        send_frame(8'h12, 1'b1, -1, 1'b0);
        idle(4);
        check("t6_data", bus_if.data, 8'h12);
        check("t6_ready", {7'd0, bus_if.ready}, 8'h01);
        check("t6_ovr", {7'd0, bus_if.overrun}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tty_rx.md
Name: tty_rx

Overview:
- Serial receive front end for the PDP-8 console TTY keyboard (KL8E-style keyboard flag and buffer).
- Sits between the board RxD pin and the CPU's keyboard IOT logic; runs on the 25 MHz divided `clk`.
- Deserialises 8N1 async frames with 16x oversampling and holds one received character.
- Raises a ready flag (KSF) that the CPU clears with a read strobe (KRB/KCC).

Parameters:
CLK_HZ, 25000000, frequency of clk in Hz
BAUD, 9600, serial bit rate
OVERSAMPLE, 16, sample ticks per bit; fixed at 16, other values unsupported
DIV, (CLK_HZ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE), derived local constant, clocks per sample tick (163 at defaults)

Ports:
clk  input  1  system clock, all logic on rising edge
nReset  input  1  synchronous active-low reset
rx  input  1  raw async serial line, idle high
rdStrobe  input  1  one-cycle pulse from CPU: character consumed, clears flags
data  output  8  received character, LSB first on wire
ready  output  1  keyboard flag: unread character in data
frameErr  output  1  last stored character had stop bit = 0
overrun  output  1  a character arrived while ready was still 1
busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (nReset=0 at a clk edge): data=0x00, ready=0, frameErr=0, overrun=0, busy=0; state=IDLE; both sync flops=1; prescaler=0; tick count=0. Reset mid-frame aborts the frame; no partial character is ever stored.
- Input sync: rx passes through 2 flops; rxS is the second flop. All decisions use rxS, giving 2 cycles of input latency.
- Prescaler: counts 0..DIV-1 and emits tick when it equals DIV-1. It is forced to 0 on the IDLE->START transition so sampling aligns to the detected falling edge.
- Tick counter: 4 bits, counts ticks within a bit. It is cleared on every state transition.
- State machine:
  - IDLE: rxS=0 -> START.
  - START: on tick with count=7 (mid start bit), rxS=1 -> IDLE (glitch rejected, nothing flagged); rxS=0 -> DATA with bit index 0 and count 0.
  - DATA: on tick with count=15, shift rxS into shift[7] (right shift, LSB first) and increment bit index. After the 8th bit -> STOP.
  - STOP: on tick with count=15, sample the stop bit and commit (below). rxS=1 -> IDLE; rxS=0 -> BREAK.
  - BREAK: wait for rxS=1, then -> IDLE. This prevents a held-low line from retriggering. No further characters are stored while in BREAK.
- Commit (the cycle after the stop sample edge, registered):
  - data <= shift; ready <= 1; frameErr <= ~stopBit.
  - overrun <= overrun | ready_prev, where ready_prev is ready before this commit.
  - A framing-error character is still stored.
- rdStrobe with no commit in the same cycle: ready, frameErr and overrun all go to 0 next cycle; data holds its value.
- rdStrobe and commit in the same cycle: the commit wins. ready=1, data=new character, frameErr=new value, overrun=0 (the old character counts as consumed).
- rdStrobe while ready=0 has no effect.
- Overall latency: ready rises at most DIV+3 clocks after the mid-point of the stop bit on the pin.
- Tolerance: samples land at bit centres ±1 tick, which tolerates about ±4% total baud mismatch.

Decomposition:
- Shared package/include: state encoding localparams (IDLE, START, DATA, STOP, BREAK, 3 bits) and the DIV computation macro. The same macro is reused by the matching tty_tx.
- One natural sub-module: baud_tick (prescaler with sync clear, parameter DIV, outputs tick). It is reusable by tty_tx.
- Sync flops, FSM and holding register stay in tty_rx.

Test Plan:
All scenarios run with CLK_HZ=640000, BAUD=10000, so DIV=4 and 64 clk per bit.
1. Send 0x41 (8N1, stop=1) -> ready=1 within 64*9.5+7 clks of the falling start edge; data=0x41; frameErr=0; overrun=0; busy returns to 0.
2. rx low pulse of 20 clks, then high -> state returns to IDLE; ready stays 0 and data stays 0x00.
3. Send 0x55 with stop bit = 0, line held low 200 clks, then high -> data=0x55, ready=1, frameErr=1; no second character while low. Then send 0x0F -> data=0x0F, overrun=1, frameErr=0.
4. Send 0xA5 then 0x3C without rdStrobe -> data=0x3C, ready=1, overrun=1. Pulse rdStrobe -> ready=0, overrun=0, data still 0x3C.
5. Pulse rdStrobe in exactly the commit cycle of a second character 0x7E, with the first still unread -> ready=1, data=0x7E, overrun=0.
6. Assert nReset=0 for 1 clk during DATA bit 4 of 0xFF -> all outputs 0 next cycle. A subsequent clean 0x12 is received correctly (data=0x12, ready=1).
